// File: rtl/fp32_pkg.sv
// Shared constants, FSM state encoding and field bundle for the sequential FP32 subtractor.
package fp32_pkg;

  localparam int unsigned WIDTH         = 32;
  localparam int unsigned EXPONENTWIDTH = 8;
  localparam int unsigned MANTISSAWIDTH = 23;

  // Mantissa register: carry, hidden bit, stored mantissa, guard bit.
  localparam int unsigned MREG_W    = MANTISSAWIDTH + 3;
  localparam int unsigned ALIGN_CAP = 26;
  localparam int unsigned CNT_W     = 5;

  localparam logic [WIDTH-1:0]         FP32_QNAN = 32'h7FC00000;
  localparam logic [EXPONENTWIDTH-1:0] EXP_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SUB,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic                     sign;
    logic [EXPONENTWIDTH-1:0] expo;
    logic [MANTISSAWIDTH-1:0] mant;
    logic                     is_zero;
    logic                     is_inf;
    logic                     is_nan;
  } fp32_fields_t;

endpackage

// File: rtl/f32_unpack.sv
// Splits an FP32 word into fields and classifies it; denormals read as zero.
module f32_unpack
  import fp32_pkg::*;
(
  input  logic [WIDTH-1:0] word,
  output fp32_fields_t     fields
);

  logic exp_zero;
  logic exp_ones;
  logic mant_zero;

  // Field split and zero/inf/nan classification.
  always_comb begin
    exp_zero       = (word[WIDTH-2 -: EXPONENTWIDTH] == '0);
    exp_ones       = (word[WIDTH-2 -: EXPONENTWIDTH] == EXP_MAX);
    mant_zero      = (word[MANTISSAWIDTH-1:0] == '0);
    fields         = '0;
    fields.sign    = word[WIDTH-1];
    fields.expo    = word[WIDTH-2 -: EXPONENTWIDTH];
    fields.mant    = word[MANTISSAWIDTH-1:0];
    fields.is_zero = exp_zero;
    fields.is_inf  = exp_ones && mant_zero;
    fields.is_nan  = exp_ones && !mant_zero;
  end

endmodule

// File: rtl/sub_f32_seq.sv
// Multi-cycle FP32 subtractor: diff = a - b, bit-serial align/normalize, truncating rounding.
module sub_f32_seq
  import fp32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff
);

  fp32_fields_t fa;
  fp32_fields_t fb;

  f32_unpack u_unpack_a (.word(a), .fields(fa));
  f32_unpack u_unpack_b (.word(b), .fields(fb));

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [MREG_W-1:0]        m_l;
  logic [MREG_W-1:0]        m_s;
  logic [EXPONENTWIDTH-1:0] exp_q;
  logic                     sign_q;
  logic                     eff_sub;
  logic [WIDTH-1:0]         diff_q;

  logic                     sb_eff;
  logic                     a_larger;
  logic                     sign_l;
  logic [EXPONENTWIDTH-1:0] exp_l;
  logic [EXPONENTWIDTH-1:0] exp_s;
  logic [MANTISSAWIDTH-1:0] mant_l;
  logic [MANTISSAWIDTH-1:0] mant_s;
  logic [EXPONENTWIDTH-1:0] exp_gap;
  logic [CNT_W-1:0]         align_cnt;
  logic                     special_hit;
  logic [WIDTH-1:0]         special_word;
  logic [MREG_W-1:0]        sum_c;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign diff      = diff_q;

  // Operand ordering by magnitude and alignment distance, evaluated at accept.
  always_comb begin
    sb_eff    = ~fb.sign;
    a_larger  = ({fa.expo, fa.mant} >= {fb.expo, fb.mant});
    sign_l    = a_larger ? fa.sign : sb_eff;
    exp_l     = a_larger ? fa.expo : fb.expo;
    exp_s     = a_larger ? fb.expo : fa.expo;
    mant_l    = a_larger ? fa.mant : fb.mant;
    mant_s    = a_larger ? fb.mant : fa.mant;
    exp_gap   = exp_l - exp_s;
    align_cnt = (exp_gap > EXPONENTWIDTH'(ALIGN_CAP)) ? CNT_W'(ALIGN_CAP) : CNT_W'(exp_gap);
  end

  // Special-operand results, in priority order; these bypass the datapath.
  always_comb begin
    special_hit  = 1'b1;
    special_word = '0;
    if (fa.is_nan || fb.is_nan) begin
      special_word = FP32_QNAN;
    end else if (fa.is_inf && fb.is_inf && (fa.sign == fb.sign)) begin
      special_word = FP32_QNAN;
    end else if (fa.is_inf) begin
      special_word = a;
    end else if (fb.is_inf) begin
      special_word = {~b[WIDTH-1], b[WIDTH-2:0]};
    end else if (fa.is_zero && fb.is_zero) begin
      special_word = '0;
    end else if (fa.is_zero) begin
      special_word = {~b[WIDTH-1], b[WIDTH-2:0]};
    end else if (fb.is_zero) begin
      special_word = a;
    end else begin
      special_hit = 1'b0;
    end
  end

  // Magnitude add or subtract of the aligned significands; L >= S so no borrow out.
  always_comb begin
    sum_c = eff_sub ? (m_l - m_s) : (m_l + m_s);
  end

  // Control FSM with the mantissa/exponent datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      m_l     <= '0;
      m_s     <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      eff_sub <= 1'b0;
      diff_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (special_hit) begin
              diff_q <= special_word;
              state  <= DONE;
            end else begin
              m_l     <= {1'b0, 1'b1, mant_l, 1'b0};
              m_s     <= {1'b0, 1'b1, mant_s, 1'b0};
              exp_q   <= exp_l;
              sign_q  <= sign_l;
              eff_sub <= (fa.sign != sb_eff);
              cnt     <= align_cnt;
              // A zero distance skips ALIGN; otherwise the last shift enters SUB.
              state   <= (align_cnt == '0) ? SUB : ALIGN;
            end
          end
        end
        ALIGN: begin
          m_s <= m_s >> 1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= SUB;
          end
        end
        SUB: begin
          if (sum_c[MREG_W-1]) begin
            if (exp_q == EXP_MAX - EXPONENTWIDTH'(1)) begin
              diff_q <= {sign_q, EXP_MAX, MANTISSAWIDTH'(0)};
              state  <= DONE;
            end else begin
              m_l   <= sum_c >> 1;
              exp_q <= exp_q + EXPONENTWIDTH'(1);
              state <= NORM;
            end
          end else begin
            m_l   <= sum_c;
            state <= NORM;
          end
        end
        NORM: begin
          if (m_l == '0) begin
            diff_q <= '0;
            state  <= DONE;
          end else if (m_l[MREG_W-2]) begin
            diff_q <= {sign_q, exp_q, m_l[MANTISSAWIDTH:1]};
            state  <= DONE;
          end else if (exp_q == EXPONENTWIDTH'(1)) begin
            diff_q <= '0;
            state  <= DONE;
          end else begin
            m_l   <= m_l << 1;
            exp_q <= exp_q - EXPONENTWIDTH'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
